// File: rtl/precedence_scheduler.sv
// Operator-precedence scheduler: stacks pending operators and issues one reduce per pop. Optional macro PREC_RIGHT_ASSOC_EN.
// Latency: accept N, compare N+1, next accept N+2 without pops; each pop adds 2 cycles with rd_ready high.
// Backpressure: in_ready is low outside IDLE or after err; rd_valid/rd_op are held until rd_ready.
module precedence_scheduler #(
    parameter int CO_N  = 4,
    parameter int DEPTH = 8,
    parameter int PL_N  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic [CO_N-1:0]            in_op,
    input  logic                       pt_we,
    input  logic [CO_N-1:0]            pt_addr,
    input  logic [PL_N-1:0]            pt_prec,
    input  logic                       pt_rassoc,
    output logic                       rd_valid,
    output logic [CO_N-1:0]            rd_op,
    input  logic                       rd_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NT = 1 << CO_N;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMP   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam logic [1:0] K_OP    = 2'd0;
    localparam logic [1:0] K_OPEN  = 2'd1;
    localparam logic [1:0] K_CLOSE = 2'd2;
    localparam logic [1:0] K_FLUSH = 2'd3;

    logic [1:0]      state;
    logic [1:0]      kind_q;
    logic [CO_N-1:0] op_q;
    logic [CO_N-1:0] rd_op_q;
    logic [DW-1:0]   cnt;
    logic            err_q;
    logic [CO_N:0]   stack [DEPTH];
    logic [PL_N-1:0] prec_tab [NT];
`ifdef PREC_RIGHT_ASSOC_EN
    logic            rassoc_tab [NT];
`endif

    logic [AW-1:0]   top_idx;
    logic [CO_N:0]   top_ent;
    logic            empty;
    logic            top_mark;
    logic            pop_ok;
    logic            push_req;
    logic [CO_N:0]   push_ent;
    logic            pop_req;
    logic            discard;
    logic            cmp_err;

    assign top_idx  = AW'(cnt - DW'(1));
    assign top_ent  = stack[top_idx];
    assign empty    = (cnt == '0);
    assign top_mark = top_ent[CO_N];

`ifdef PREC_RIGHT_ASSOC_EN
    assign pop_ok = rassoc_tab[op_q] ? (prec_tab[top_ent[CO_N-1:0]] >  prec_tab[op_q])
                                     : (prec_tab[top_ent[CO_N-1:0]] >= prec_tab[op_q]);
`else
    assign pop_ok = (prec_tab[top_ent[CO_N-1:0]] >= prec_tab[op_q]);
`endif

    always_comb begin
        push_req = 1'b0;
        push_ent = '0;
        pop_req  = 1'b0;
        discard  = 1'b0;
        cmp_err  = 1'b0;
        if (state == S_CMP) begin
            case (kind_q)
                K_OP: begin
                    if (!empty && !top_mark && pop_ok) begin
                        pop_req = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_ent = {1'b0, op_q};
                    end
                end
                K_OPEN: begin
                    push_req = 1'b1;
                    push_ent = {1'b1, {CO_N{1'b0}}};
                end
                K_CLOSE: begin
                    if (empty)         cmp_err = 1'b1;
                    else if (top_mark) discard = 1'b1;
                    else               pop_req = 1'b1;
                end
                default: begin
                    if (!empty) begin
                        if (top_mark) cmp_err = 1'b1;
                        else          pop_req = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            kind_q  <= K_OP;
            op_q    <= '0;
            rd_op_q <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            for (int i = 0; i < NT; i++) begin
                prec_tab[i] <= '0;
`ifdef PREC_RIGHT_ASSOC_EN
                rassoc_tab[i] <= 1'b0;
`endif
            end
        end else begin
            // Table writes land at the edge, so a same-cycle CMP read sees the old entry.
            if (pt_we) begin
                prec_tab[pt_addr] <= pt_prec;
`ifdef PREC_RIGHT_ASSOC_EN
                rassoc_tab[pt_addr] <= pt_rassoc;
`endif
            end
            if (err_q) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            kind_q <= in_kind;
                            op_q   <= in_op;
                            state  <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        state <= S_IDLE;
                        if (cmp_err || (push_req && cnt == FULL)) begin
                            err_q <= 1'b1;
                        end else if (pop_req) begin
                            rd_op_q <= top_ent[CO_N-1:0];
                            state   <= S_ISSUE;
                        end else if (push_req) begin
                            stack[AW'(cnt)] <= push_ent;
                            cnt <= cnt + DW'(1);
                        end else if (discard) begin
                            cnt <= cnt - DW'(1);
                        end
                    end
                    S_ISSUE: begin
                        if (rd_ready) begin
                            cnt   <= cnt - DW'(1);
                            state <= S_CMP;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Reset gates the handshakes combinationally so a pending request vanishes at once.
    assign in_ready = (state == S_IDLE) && !err_q && !reset;
    assign rd_valid = (state == S_ISSUE) && !err_q && !reset;
    assign rd_op    = rd_op_q;
    assign busy     = (state != S_IDLE);
    assign depth    = cnt;
    assign err      = err_q;

    logic unused_ok;
    assign unused_ok = pt_rassoc;
endmodule
